// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int unsigned LATENCY_DEFAULT = 4;
    localparam int unsigned CNT_W           = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mem_arb_counter.sv
// ============================================================================
// Module      : mem_arb_counter
// Description : Loadable down-counter; o_tc flags the final counted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch/data) arbiter for a single-port memory
//               with fixed access latency. Define MEM_ARB_ROUND_ROBIN_EN to
//               alternate grants when both sides request together.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        i_cancel,
    output logic        i_valid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    logic [1:0]       r_state;
    logic             r_owner_d;
    logic             r_cancel;
    logic             r_wr;
    logic [15:0]      r_addr;
    logic [15:0]      r_wdata;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_in_busy;
    logic             w_tc;
    logic [CNT_W-1:0] w_count;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // On contention the side that did not win last time takes this grant.
    assign w_grant_d = (r_state == ST_IDLE) && d_req && (!i_req || !r_last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
        end
    end
`else
    assign w_grant_d = (r_state == ST_IDLE) && d_req;
`endif

    assign w_grant_i = (r_state == ST_IDLE) && i_req && !w_grant_d;
    assign w_in_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

    mem_arb_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant_d || w_grant_i),
        .i_load_val (CNT_W'(LATENCY)),
        .i_dec      (w_in_busy),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_cancel  <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_BUSY_D;
                        r_owner_d <= 1'b1;
                        r_cancel  <= 1'b0;
                        r_wr      <= d_wr;
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state   <= ST_BUSY_I;
                        r_owner_d <= 1'b0;
                        r_cancel  <= 1'b0;
                        r_wr      <= 1'b0;
                        r_addr    <= i_addr;
                        r_wdata   <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // A redirect only marks the fetch; the memory cycle still runs out.
                    if ((r_state == ST_BUSY_I) && i_cancel) begin
                        r_cancel <= 1'b1;
                    end
                    if (w_tc) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = w_in_busy && (w_count == CNT_W'(LATENCY));
    assign mem_wr    = mem_en && r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign i_valid = (r_state == ST_DONE) && !r_owner_d && !r_cancel && !i_cancel;
    assign d_valid = (r_state == ST_DONE) && r_owner_d;
    assign i_rdata = i_valid ? mem_rdata : 16'h0000;
    assign d_rdata = d_valid ? mem_rdata : 16'h0000;
    assign busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; memory returns address ^ 16'h5A5A.
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_cancel, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_valid, d_valid, mem_en, mem_wr, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        d1_req;
    logic [15:0] d1_addr;
    logic        i1_valid, d1_valid, mem1_en, mem1_wr, busy1;
    logic [15:0] i1_rdata, d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

    int checks = 0;
    int errors = 0;

    logic        en [0:31];
    logic        wrr[0:31];
    logic        iv [0:31];
    logic        dv [0:31];
    logic        bz [0:31];
    logic [15:0] ad [0:31];
    logic [15:0] wd [0:31];
    logic [15:0] ird[0:31];
    logic [15:0] drd[0:31];

    always #5 clk = ~clk;

    assign mem_rdata  = mem_addr ^ 16'h5A5A;
    assign mem1_rdata = mem1_addr ^ 16'h5A5A;

    mem_arbiter #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(1'b0), .i_addr(16'h0000), .i_cancel(1'b0),
        .i_valid(i1_valid), .i_rdata(i1_rdata),
        .d_req(d1_req), .d_wr(1'b0), .d_addr(d1_addr), .d_wdata(16'h0000),
        .d_valid(d1_valid), .d_rdata(d1_rdata),
        .mem_en(mem1_en), .mem_wr(mem1_wr), .mem_addr(mem1_addr),
        .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata), .busy(busy1)
    );

    task automatic sample(input int c);
        en[c]  = mem_en;   wrr[c] = mem_wr;  ad[c]  = mem_addr; wd[c] = mem_wdata;
        iv[c]  = i_valid;  dv[c]  = d_valid; bz[c]  = busy;
        ird[c] = i_rdata;  drd[c] = d_rdata;
    endtask

    task automatic sync_cycle0();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 0; i_cancel = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        d1_req = 0; d1_addr = 0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if ({i_valid, d_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b expected 00", {i_valid, d_valid}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        sync_cycle0();
        i_addr = 16'h0000; i_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            @(negedge clk); sample(c);
            if (i_valid) i_req = 1'b0;
        end
        checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL fetch_en_c1: got %b expected 1", en[1]); end
        checks++; if (ad[1] !== 16'h0000) begin errors++; $display("FAIL fetch_addr_c1: got %h expected 0000", ad[1]); end
        checks++; if (en[2] !== 1'b0) begin errors++; $display("FAIL fetch_en_c2: got %b expected 0", en[2]); end
        checks++; if (iv[4] !== 1'b0) begin errors++; $display("FAIL fetch_valid_c4: got %b expected 0", iv[4]); end
        checks++; if (iv[5] !== 1'b1) begin errors++; $display("FAIL fetch_valid_c5: got %b expected 1", iv[5]); end
        checks++; if (ird[5] !== 16'h5A5A) begin errors++; $display("FAIL fetch_rdata: got %h expected 5a5a", ird[5]); end
        checks++; if (bz[5] !== 1'b1 || bz[6] !== 1'b0) begin errors++; $display("FAIL fetch_busy_c5c6: got %b%b expected 10", bz[5], bz[6]); end
        checks++; if (dv[5] !== 1'b0) begin errors++; $display("FAIL fetch_no_dvalid: got %b expected 0", dv[5]); end
    endtask

    task automatic test_d_read_latch();
        int n_iv;
        sync_cycle0();
        d_addr = 16'h0200; d_wr = 1'b0; d_req = 1'b1;
        n_iv = 0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 2) d_addr = 16'h0300;
            i_cancel = (c >= 3 && c <= 5);
            @(negedge clk); sample(c);
            if (i_valid) n_iv++;
            if (d_valid) d_req = 1'b0;
        end
        i_cancel = 1'b0;
        checks++; if (ad[1] !== 16'h0200) begin errors++; $display("FAIL dread_addr_c1: got %h expected 0200", ad[1]); end
        checks++; if (dv[5] !== 1'b1) begin errors++; $display("FAIL dread_valid_c5 (cancel ignored): got %b expected 1", dv[5]); end
        checks++; if (drd[5] !== (16'h0200 ^ 16'h5A5A)) begin errors++; $display("FAIL dread_latched_rdata: got %h expected 585a", drd[5]); end
        checks++; if (n_iv !== 0) begin errors++; $display("FAIL dread_no_ivalid: got %0d expected 0", n_iv); end
    endtask

    task automatic test_priority();
        int ov;
        sync_cycle0();
        i_addr = 16'h0100; i_req = 1'b1;
        d_addr = 16'h0040; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
        ov = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            @(negedge clk); sample(c);
            if (i_valid && d_valid) ov++;
            if (d_valid) d_req = 1'b0;
            if (i_valid) i_req = 1'b0;
        end
        d_wr = 1'b0;
        checks++; if ({en[1], wrr[1]} !== 2'b11) begin errors++; $display("FAIL prio_d_write_c1: got %b expected 11", {en[1], wrr[1]}); end
        checks++; if (ad[1] !== 16'h0040 || wd[1] !== 16'hBEEF) begin errors++; $display("FAIL prio_d_addr_data: got %h/%h expected 0040/beef", ad[1], wd[1]); end
        checks++; if (dv[5] !== 1'b1) begin errors++; $display("FAIL prio_dvalid_c5: got %b expected 1", dv[5]); end
        checks++; if (en[3+4] !== 1'b1 || en[6] !== 1'b0) begin errors++; $display("FAIL prio_i_en_c7: got c6=%b c7=%b expected 0 1", en[6], en[7]); end
        checks++; if (ad[7] !== 16'h0100 || wrr[7] !== 1'b0) begin errors++; $display("FAIL prio_i_addr_c7: got %h wr=%b expected 0100 wr=0", ad[7], wrr[7]); end
        checks++; if (iv[11] !== 1'b1 || ird[11] !== (16'h0100 ^ 16'h5A5A)) begin errors++; $display("FAIL prio_ivalid_c11: got %b %h expected 1 5b5a", iv[11], ird[11]); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL prio_valid_overlap: got %0d expected 0", ov); end
    endtask

    task automatic test_both_held();
        int n_iv;
        sync_cycle0();
        i_addr = 16'h0100; i_req = 1'b1;
        d_addr = 16'h0D00; d_wr = 1'b0; d_req = 1'b1;
        n_iv = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            @(negedge clk); sample(c);
            if (i_valid) n_iv++;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (8) @(posedge clk);
        checks++; if (en[1] !== 1'b1 || ad[1] !== 16'h0D00) begin errors++; $display("FAIL held_grant1: got en=%b %h expected 1 0d00", en[1], ad[1]); end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        checks++; if (en[7] !== 1'b1 || ad[7] !== 16'h0100) begin errors++; $display("FAIL held_grant2: got en=%b %h expected 1 0100", en[7], ad[7]); end
        checks++; if (n_iv !== 1) begin errors++; $display("FAIL held_ivalid_count: got %0d expected 1", n_iv); end
`else
        checks++; if (en[7] !== 1'b1 || ad[7] !== 16'h0D00) begin errors++; $display("FAIL held_grant2: got en=%b %h expected 1 0d00", en[7], ad[7]); end
        checks++; if (n_iv !== 0) begin errors++; $display("FAIL held_ivalid_count: got %0d expected 0", n_iv); end
`endif
        checks++; if (en[13] !== 1'b1 || ad[13] !== 16'h0D00) begin errors++; $display("FAIL held_grant3: got en=%b %h expected 1 0d00", en[13], ad[13]); end
    endtask

    task automatic test_cancel();
        int n_iv;
        sync_cycle0();
        i_addr = 16'h0010; i_req = 1'b1;
        n_iv = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin i_cancel = 1'b1; i_req = 1'b0; end
            if (c == 4) i_cancel = 1'b0;
            if (c == 6) begin i_addr = 16'h0300; i_req = 1'b1; end
            @(negedge clk); sample(c);
            if (i_valid && c <= 6) n_iv++;
            if (i_valid) i_req = 1'b0;
        end
        checks++; if (n_iv !== 0) begin errors++; $display("FAIL cancel_no_ivalid: got %0d expected 0", n_iv); end
        checks++; if (bz[5] !== 1'b1 || bz[6] !== 1'b0) begin errors++; $display("FAIL cancel_busy_c5c6: got %b%b expected 10", bz[5], bz[6]); end
        checks++; if (en[7] !== 1'b1 || ad[7] !== 16'h0300) begin errors++; $display("FAIL cancel_next_en_c7: got en=%b %h expected 1 0300", en[7], ad[7]); end
        checks++; if (iv[11] !== 1'b1 || ird[11] !== (16'h0300 ^ 16'h5A5A)) begin errors++; $display("FAIL cancel_next_valid: got %b %h expected 1 595a", iv[11], ird[11]); end
    endtask

    task automatic test_reset_abort();
        int n_dv;
        sync_cycle0();
        d_addr = 16'h0400; d_wr = 1'b0; d_req = 1'b1;
        n_dv = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                rst = 1'b1;
                #1;
                checks++; if ({busy, mem_en, d_valid} !== 3'b000) begin errors++; $display("FAIL abort_outputs: got busy/en/dv=%b expected 000", {busy, mem_en, d_valid}); end
                checks++; if (mem_addr !== 16'h0000 || d_rdata !== 16'h0000) begin errors++; $display("FAIL abort_buses: got %h/%h expected 0000/0000", mem_addr, d_rdata); end
            end
            if (c == 4) rst = 1'b0;
            @(negedge clk); sample(c);
            if (d_valid && c <= 4) n_dv++;
            if (d_valid) d_req = 1'b0;
        end
        checks++; if (n_dv !== 0) begin errors++; $display("FAIL abort_no_dvalid: got %0d expected 0", n_dv); end
        checks++; if (en[5] !== 1'b1 || ad[5] !== 16'h0400) begin errors++; $display("FAIL abort_regrant_c5: got en=%b %h expected 1 0400", en[5], ad[5]); end
        checks++; if (dv[9] !== 1'b1 || drd[9] !== (16'h0400 ^ 16'h5A5A)) begin errors++; $display("FAIL abort_regrant_valid: got %b %h expected 1 5e5a", dv[9], drd[9]); end
    endtask

    task automatic test_latency1();
        logic e1[0:15];
        logic v1[0:15];
        sync_cycle0();
        d1_addr = 16'h0777; d1_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            e1[c] = mem1_en; v1[c] = d1_valid;
        end
        d1_req = 1'b0;
        checks++; if ({e1[1], e1[2], e1[3]} !== 3'b100) begin errors++; $display("FAIL lat1_en_c1to3: got %b expected 100", {e1[1], e1[2], e1[3]}); end
        checks++; if ({e1[4], e1[7]} !== 2'b11) begin errors++; $display("FAIL lat1_en_c4c7: got %b expected 11", {e1[4], e1[7]}); end
        checks++; if ({v1[2], v1[3], v1[5], v1[8]} !== 4'b1011) begin errors++; $display("FAIL lat1_valid: got %b expected 1011", {v1[2], v1[3], v1[5], v1[8]}); end
        checks++; if (mem1_addr !== 16'h0777) begin errors++; $display("FAIL lat1_addr: got %h expected 0777", mem1_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_d_read_latch();
        test_priority();
        test_both_held();
        test_cancel();
        test_reset_abort();
        test_latency1();
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set memory read/write latency in cycles (legal 1..15).
REQ-002 clk  input  1  SHALL be the single system clock; all state on rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 i_req  input  1  SHALL be the instruction-fetch request, held high until i_valid.
REQ-005 i_addr  input  16  SHALL be the fetch address, stable while i_req high.
REQ-006 i_cancel  input  1  SHALL be the fetch discard (branch/redirect) for the outstanding fetch.
REQ-007 i_valid / i_rdata  output  1/16  SHALL be the fetch completion pulse and data.
REQ-008 d_req, d_wr  input  1,1  SHALL be the data request and write-select, held until d_valid.
REQ-009 d_addr, d_wdata  input  16,16  SHALL be the data address and write data.
REQ-010 d_valid / d_rdata  output  1/16  SHALL be the data completion pulse and read data.
REQ-011 mem_en, mem_wr  output  1,1  SHALL be the single-port memory strobe and write-select.
REQ-012 mem_addr, mem_wdata  output  16,16  SHALL be the memory address and write data.
REQ-013 mem_rdata  input  16  SHALL be memory read data, valid LATENCY cycles after the mem_en cycle.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, BUSY_I, BUSY_D, DONE SHALL be the only states.
REQ-016 In IDLE, sampled d_req SHALL move to BUSY_D; else sampled i_req SHALL move to BUSY_I; else remain IDLE.
REQ-017 Address/wdata/wr SHALL be latched at the granting edge; requester changes afterward SHALL NOT affect the access.
REQ-018 mem_en SHALL be high for exactly the first BUSY cycle, with mem_addr/mem_wr/mem_wdata from the latch; mem_en SHALL be low in all other cycles.
REQ-019 A 4-bit counter SHALL count BUSY cycles; after LATENCY cycles the FSM SHALL enter DONE.
REQ-020 In DONE, the granted requester's valid SHALL pulse for one cycle with rdata = mem_rdata; the FSM SHALL then return to IDLE (one bubble cycle per access).
REQ-021 Writes SHALL produce d_valid as an acknowledge at the same point; d_rdata SHALL be don't-care.
REQ-022 Timing: request sampled at end of cycle 0 -> mem_en in cycle 1 -> valid in cycle 1+LATENCY; next grant's mem_en no earlier than cycle 3+LATENCY.
REQ-023 i_cancel high in any cycle of BUSY_I or DONE for an I access SHALL suppress that i_valid; the memory cycle SHALL still complete.
REQ-024 i_cancel SHALL be ignored outside an I access; d-side accesses SHALL never be cancelled.
REQ-025 Requests arriving while not IDLE SHALL wait; none SHALL be lost or duplicated.
REQ-026 i_valid and d_valid SHALL never be high in the same cycle.

Reset
REQ-027 rst SHALL force IDLE, counter 0, latches 0, last-grant = I, and all outputs 0 immediately.
REQ-028 rst during BUSY/DONE SHALL abort the access with no valid pulse; requests still held after rst release SHALL be re-arbitrated.

Configuration
REQ-029 With MEM_ARB_ROUND_ROBIN_EN defined, in IDLE with both requests pending, the requester not granted last SHALL win.
REQ-030 Without MEM_ARB_ROUND_ROBIN_EN, D SHALL always win over I, and the last-grant register SHALL not exist.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state encoding, LATENCY default, and counter width.
REQ-032 Sub-module mem_arb_counter (load/decrement latency counter with terminal-count output) SHALL be the only child.

Verification
REQ-033 Reset, i_req=1, i_addr=0x0000, LATENCY=4 -> mem_en in cycle 1 with addr 0x0000; i_valid in cycle 5 with i_rdata = mem_rdata.
REQ-034 i_req and d_req (write 0xBEEF to 0x0040) in the same cycle -> D granted first; I mem_en in cycle 7; no overlap of valids.
REQ-035 Both held continuously with MEM_ARB_ROUND_ROBIN_EN -> grants alternate D,I,D,I; without it -> I starved while d_req held.
REQ-036 i_cancel pulsed in cycle 3 of a fetch -> no i_valid; busy low in cycle 6; next request granted normally.
REQ-037 rst asserted in cycle 3 of a D read -> outputs 0 asynchronously; no d_valid; held d_req re-granted after release.
REQ-038 LATENCY=1 build -> mem_en cycle 1, valid cycle 2, back-to-back accesses every 3 cycles.
